moore_seq_detect: RTL and testbench
===================================

// Module: moore_seq_detect
// PURPOSE
//   Parametrised Moore sequence detector: generalises the fixed "000x" bit-serial FSM.
//   Width N, runtime-loadable pattern with don't-care mask, overlap/non-overlap mode,
//   saturating match counter. Sits on a serial bit stream; y is a registered Moore flag.
// PARAMETERS
//   N        4        pattern length in bits, legal 2..16
//   DEF_PAT  4'b0000  reset pattern, N bits; bit0 = newest bit, bit N-1 = oldest
//   DEF_MASK 4'b1110  reset care-mask, N bits; 1 = compare, 0 = don't care (reset = "000x")
//   CNT_W    8        match counter width
// PORTS
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-low reset
//   x         in   1      serial data bit
//   en        in   1      sample x on this edge
//   overlap   in   1      1 = overlapping matches, 0 = non-overlapping
//   cfg_we    in   1      load cfg_pat/cfg_mask this edge
//   cfg_pat   in   N      new pattern
//   cfg_mask  in   N      new care-mask
//   clr       in   1      clear match counter
//   y         out  1      Moore match flag
//   count     out  CNT_W  saturating number of matches
//   fill      out  5      bits accumulated since reset/cfg/match (0..N, saturates at N)
// BEHAVIOUR
//   State: hist[N-1:0], fill, pat, mask, count, y. No combinational path from inputs to outputs.
//   Reset (reset=0, async): hist=0, fill=0, y=0, count=0, pat=DEF_PAT, mask=DEF_MASK.
//   Edge priority: cfg_we > en > idle.
//   cfg_we=1: pat<=cfg_pat, mask<=cfg_mask, hist<=0, fill<=0, y<=0; x ignored; count kept
//     unless clr.
//   en=1, cfg_we=0:
//     hist_n = {hist[N-2:0], x}; fill_n = (fill==N) ? N : fill+1
//     match  = (fill_n==N) && (((hist_n ^ pat) & mask) == 0)
//     hist<=hist_n; y<=match
//     fill <= (match && !overlap) ? 0 : fill_n   (non-overlap: next match needs N fresh bits)
//   en=0, cfg_we=0: hist, fill hold; y<=0 (y is high exactly one cycle per match).
//   Latency: y rises on the edge that samples the final pattern bit; visible the following cycle.
//   mask=0: every sample with fill_n==N matches.
//   Counter: on match, count <= count+1, saturating at 2^CNT_W-1 (no wrap).
//     clr=1 forces count<=0 and wins over a simultaneous match.
//   FSM view: FILL (fill<N) -> ARMED (fill==N) on Nth sample; ARMED -> HIT (y=1) on match;
//     HIT -> ARMED (overlap) or FILL (non-overlap); any state -> FILL on cfg_we or reset.
//   Reset mid-stream discards partial history; no match until N new bits are sampled.
//   overlap is sampled per edge; changing it mid-stream affects only the next match.
// TESTING
//   T1 defaults, en=1, x=0,0,0,1 then 1,0,0,0,0 -> y=1 after 4th bit; y=1 after 9th; count=2.
//   T2 overlap=1, x=0 for 8 cycles -> y=0,0,0,1,1,1,1,1; count=5; fill holds 4.
//   T3 overlap=0, x=0 for 8 cycles -> y=1 on samples 4 and 8 only; count=2; fill 0 after each hit.
//   T4 cfg_we pat=4'b1011 mask=4'b1111 mid-stream, then x=1,0,1,1,0,1,1 -> y on samples 4 and 7
//      (overlap=1); en gaps between bits stretch the stream but do not break the match.
//   T5 CNT_W=3, 10 matches, clr asserted on the 10th match edge -> count saturates at 7, then 0.
//   T6 reset low after x=0,0,0 -> y=0, fill=0; next x=1 gives no match; x=0,0,0,0 gives y=1.

Source files
------------

// File: rtl/moore_seq_detect.sv
// Parametrised Moore sequence detector on a serial bit stream: loadable pattern with
// care-mask, overlap/non-overlap matching and a saturating match counter.
module moore_seq_detect #(
  parameter int unsigned    N        = 4,
  parameter logic [N-1:0]   DEF_PAT  = 4'b0000,
  parameter logic [N-1:0]   DEF_MASK = 4'b1110,
  parameter int unsigned    CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             en,
  input  logic             overlap,
  input  logic             cfg_we,
  input  logic [N-1:0]     cfg_pat,
  input  logic [N-1:0]     cfg_mask,
  input  logic             clr,
  output logic             y,
  output logic [CNT_W-1:0] count,
  output logic [4:0]       fill
);

  localparam logic [4:0]       FillFull = 5'(N);
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [N-1:0]     hist_q, hist_d, hist_n;
  logic [N-1:0]     pat_q, pat_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [4:0]       fill_q, fill_d, fill_n;
  logic [CNT_W-1:0] count_q, count_d;
  logic             y_q, y_d;
  logic             match;

  always_comb begin
    hist_n = {hist_q[N-2:0], x};
    fill_n = (fill_q == FillFull) ? FillFull : fill_q + 5'd1;
    match  = (fill_n == FillFull) && (((hist_n ^ pat_q) & mask_q) == '0);

    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    mask_d  = mask_q;
    count_d = count_q;
    y_d     = 1'b0;

    if (cfg_we) begin
      pat_d  = cfg_pat;
      mask_d = cfg_mask;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = hist_n;
      // Non-overlap: restart the fill so the next match needs N fresh bits.
      fill_d = (match && !overlap) ? 5'd0 : fill_n;
      y_d    = match;
      if (match && (count_q != CntMax)) begin
        count_d = count_q + CntOne;
      end
    end

    if (clr) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= DEF_PAT;
      mask_q  <= DEF_MASK;
      count_q <= '0;
      y_q     <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      y_q     <= y_d;
    end
  end

  assign y     = y_q;
  assign count = count_q;
  assign fill  = fill_q;

endmodule

// File: tb/tb_moore_seq_detect.sv
// Bench for moore_seq_detect: fixed vector table, directed corner sequences and random
// stimulus against a queue-based reference model. A CNT_W=3 copy exercises saturation.
module tb_moore_seq_detect;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       x = 1'b0, en = 1'b0, overlap = 1'b0, cfg_we = 1'b0, clr = 1'b0;
  logic [3:0] cfg_pat = '0, cfg_mask = '0;
  logic       y, y3;
  logic [7:0] count;
  logic [2:0] count3;
  logic [4:0] fill, fill3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  moore_seq_detect #(.N(4), .DEF_PAT(4'b0000), .DEF_MASK(4'b1110), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .x(x), .en(en), .overlap(overlap), .cfg_we(cfg_we),
    .cfg_pat(cfg_pat), .cfg_mask(cfg_mask), .clr(clr), .y(y), .count(count), .fill(fill)
  );

  moore_seq_detect #(.N(4), .DEF_PAT(4'b0000), .DEF_MASK(4'b1110), .CNT_W(3)) u_dut3 (
    .clk(clk), .reset(reset), .x(x), .en(en), .overlap(overlap), .cfg_we(cfg_we),
    .cfg_pat(cfg_pat), .cfg_mask(cfg_mask), .clr(clr), .y(y3), .count(count3), .fill(fill3)
  );

  // Reference model: the fresh bits seen since reset/cfg/non-overlap hit, newest last.
  bit   m_q[$];
  logic [3:0] m_pat, m_mask;
  int   m_y, m_cnt8, m_cnt3;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_pat = 4'b0000;
    m_mask = 4'b1110;
    m_y = 0;
    m_cnt8 = 0;
    m_cnt3 = 0;
  endfunction

  function automatic void model_edge(input bit xi, eni, ovi, cfgi, input logic [3:0] pi, mi,
                                     input bit clri);
    bit hit;
    hit = 1'b0;
    if (cfgi) begin
      m_pat = pi;
      m_mask = mi;
      m_q.delete();
      m_y = 0;
    end else if (eni) begin
      m_q.push_back(xi);
      if (m_q.size() > N) void'(m_q.pop_front());
      if (m_q.size() == N) begin
        hit = 1'b1;
        for (int i = 0; i < N; i++)
          if (m_mask[i] && (m_q[N-1-i] != m_pat[i])) hit = 1'b0;
      end
      m_y = hit ? 1 : 0;
      if (hit) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt3 < 7) m_cnt3++;
        if (!ovi) m_q.delete();
      end
    end else begin
      m_y = 0;
    end
    if (clri) begin
      m_cnt8 = 0;
      m_cnt3 = 0;
    end
  endfunction

  task automatic compare_model(input string tag);
    check({tag, ".y"}, int'(y), m_y);
    check({tag, ".count"}, int'(count), m_cnt8);
    check({tag, ".fill"}, int'(fill), m_q.size());
    check({tag, ".count3"}, int'(count3), m_cnt3);
    check({tag, ".y3"}, int'(y3), m_y);
  endtask

  task automatic step(input string tag, input bit xi, eni, ovi, cfgi,
                      input logic [3:0] pi, mi, input bit clri);
    @(negedge clk);
    x = xi; en = eni; overlap = ovi; cfg_we = cfgi; cfg_pat = pi; cfg_mask = mi; clr = clri;
    @(posedge clk);
    model_edge(xi, eni, ovi, cfgi, pi, mi, clri);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    en = 1'b0; cfg_we = 1'b0; clr = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    compare_model(tag);
    #2 reset = 1'b1;
  endtask

  typedef struct {
    bit x;
    int exp_y;
    int exp_cnt;
    int exp_fill;
  } vec_t;

  vec_t t1[9];
  int   hits;

  initial begin
    t1[0] = '{0, 0, 0, 1};
    t1[1] = '{0, 0, 0, 2};
    t1[2] = '{0, 0, 0, 3};
    t1[3] = '{1, 1, 1, 4};
    t1[4] = '{1, 0, 1, 4};
    t1[5] = '{0, 0, 1, 4};
    t1[6] = '{0, 0, 1, 4};
    t1[7] = '{0, 0, 1, 4};
    t1[8] = '{0, 1, 2, 4};

    model_reset();
    #3;
    do_reset("reset0");

    // T1: default "000x" pattern, vectors derived by hand.
    for (int i = 0; i < 9; i++) begin
      step("t1", t1[i].x, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      check($sformatf("t1.vec%0d.y", i), int'(y), t1[i].exp_y);
      check($sformatf("t1.vec%0d.count", i), int'(count), t1[i].exp_cnt);
      check($sformatf("t1.vec%0d.fill", i), int'(fill), t1[i].exp_fill);
    end

    // T2: overlapping zeros.
    do_reset("t2.reset");
    for (int i = 0; i < 8; i++) step("t2", 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    check("t2.count_const", int'(count), 5);
    check("t2.fill_const", int'(fill), 4);

    // T3: non-overlapping zeros.
    do_reset("t3.reset");
    for (int i = 0; i < 8; i++) step("t3", 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    check("t3.count_const", int'(count), 2);
    check("t3.fill_const", int'(fill), 0);

    // T4: reconfigure mid-stream, en gaps between bits.
    step("t4.pre", 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    step("t4.cfg", 1'b1, 1'b1, 1'b1, 1'b1, 4'b1011, 4'b1111, 1'b0);
    check("t4.cfg_fill", int'(fill), 0);
    hits = 0;
    foreach (t1[i]) begin end
    for (int i = 0; i < 7; i++) begin
      bit b;
      b = (7'b1011011 >> (6 - i)) & 1'b1;
      step("t4", b, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      hits += int'(y);
      if (i == 3) check("t4.hit4", int'(y), 1);
      step("t4.gap", ~b, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      hits += int'(y);
    end
    check("t4.hits", hits, 2);
    check("t4.y_last", int'(y), 0);

    // T5: mask=0, 10 matches, clr on the 10th match edge.
    step("t5.clr", 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
    step("t5.cfg", 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 12; i++) step("t5", 1'($urandom), 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    check("t5.sat3", int'(count3), 7);
    check("t5.cnt8", int'(count), 9);
    step("t5.clrhit", 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
    check("t5.clr_y", int'(y), 1);
    check("t5.clr3", int'(count3), 0);

    // T6: reset mid-stream discards history and restores defaults.
    do_reset("t6.reset0");
    for (int i = 0; i < 3; i++) step("t6.pre", 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    do_reset("t6.reset");
    check("t6.fill_const", int'(fill), 0);
    step("t6.one", 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    check("t6.no_hit", int'(y), 0);
    for (int i = 0; i < 4; i++) step("t6.z", 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    check("t6.hit", int'(y), 1);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] rp, rm;
      rp = 4'($urandom);
      rm = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        do_reset("rnd.reset");
      end else begin
        step("rnd", 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
             ($urandom_range(0, 49) == 0), rp, rm, ($urandom_range(0, 99) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
